// File: rtl/toy_dmem_sbuf.sv
// Data-memory slave: word SRAM behind a posted store buffer with LSU byte forwarding and a DMA port.
// Note: rst_n is asynchronous and active-high despite its name.

module toy_dmem_sbuf_entry #(
  parameter int IDX_W      = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [IDX_W-1:0]        push_idx,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic [DATA_WIDTH/8-1:0] push_strb,
  input  logic [IDX_W-1:0]        lsu_idx,
  input  logic [IDX_W-1:0]        dma_idx,
  output logic                    vld,
  output logic [IDX_W-1:0]        idx,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] strb,
  output logic                    lsu_hit,
  output logic                    dma_hit
);
  // push wins over pop: when full the tail slot is the head slot being drained
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)     vld <= 1'b0;
    else if (push) vld <= 1'b1;
    else if (pop)  vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx  <= push_idx;
      data <= push_data;
      strb <= push_strb;
    end
  end

  assign lsu_hit = vld && (idx == lsu_idx);
  assign dma_hit = vld && (idx == dma_idx);
endmodule

module toy_dmem_sbuf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 4096,
  parameter int SB_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_req_vld,
  output logic                          mem_req_rdy,
  input  logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic [DATA_WIDTH-1:0]         mem_req_data,
  input  logic [DATA_WIDTH/8-1:0]       mem_req_strb,
  input  logic                          mem_req_opcode,
  output logic                          mem_ack_vld,
  input  logic                          mem_ack_rdy,
  output logic [DATA_WIDTH-1:0]         mem_ack_data,
  input  logic                          dma_req_vld,
  output logic                          dma_req_rdy,
  input  logic [ADDR_WIDTH-1:0]         dma_req_addr,
  input  logic [DATA_WIDTH-1:0]         dma_req_data,
  input  logic [DATA_WIDTH/8-1:0]       dma_req_strb,
  input  logic                          dma_req_opcode,
  output logic                          dma_ack_vld,
  output logic [DATA_WIDTH-1:0]         dma_ack_data,
  output logic [$clog2(SB_DEPTH):0]     sb_count
);
  localparam logic TOY_BUS_READ  = 1'b0;
  localparam logic TOY_BUS_WRITE = 1'b1;
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int PTR_W  = $clog2(SB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [IDX_W-1:0] lsu_idx, dma_idx;
  logic             lsu_rd, lsu_wr, drain_hi, dma_gnt, drain;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt;

  logic [SB_DEPTH-1:0]                 ent_vld, lsu_hit, dma_hit, push_sel, pop_sel;
  logic [SB_DEPTH-1:0][IDX_W-1:0]      ent_idx;
  logic [SB_DEPTH-1:0][DATA_WIDTH-1:0] ent_data;
  logic [SB_DEPTH-1:0][STRB_W-1:0]     ent_strb;

  logic                  port_en, port_we;
  logic [IDX_W-1:0]      port_idx;
  logic [DATA_WIDTH-1:0] port_wdata;
  logic [STRB_W-1:0]     port_be;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata;

  logic [PTR_W-1:0]      fwd_slot;
  logic [DATA_WIDTH-1:0] fwd_data, fwd_data_q, merged, ack_hold, dma_hold;
  logic [STRB_W-1:0]     fwd_mask, fwd_mask_q;
  logic                  lsu_ack_q, dma_ack_q;

  // upper/lower address bits are don't-care by design; ack_rdy is tied high upstream
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_ack_rdy, ent_vld,
                       mem_req_addr[ADDR_WIDTH-1:IDX_W+2], mem_req_addr[1:0],
                       dma_req_addr[ADDR_WIDTH-1:IDX_W+2], dma_req_addr[1:0]};

  assign lsu_idx = mem_req_addr[IDX_W+1:2];
  assign dma_idx = dma_req_addr[IDX_W+1:2];

  assign lsu_rd   = mem_req_vld && (mem_req_opcode == TOY_BUS_READ);
  assign lsu_wr   = mem_req_vld && (mem_req_opcode == TOY_BUS_WRITE) && (|mem_req_strb);
  assign drain_hi = cnt >= CNT_W'(SB_DEPTH - 1);

  // A full buffer always has drain_hi set, and a write cycle has no LSU read,
  // so a write into a full buffer is always paired with a drain.
  assign dma_req_rdy = !lsu_rd && !drain_hi && !(|dma_hit);
  assign dma_gnt     = dma_req_vld && dma_req_rdy;
  assign drain       = !lsu_rd && !dma_gnt && (cnt != '0);

  assign mem_req_rdy = 1'b1;
  assign sb_count    = cnt;

  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_ent
    assign push_sel[i] = lsu_wr && (tail == PTR_W'(i));
    assign pop_sel[i]  = drain && (head == PTR_W'(i));

    toy_dmem_sbuf_entry #(.IDX_W(IDX_W), .DATA_WIDTH(DATA_WIDTH)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_sel[i]),
      .pop       (pop_sel[i]),
      .push_idx  (lsu_idx),
      .push_data (mem_req_data),
      .push_strb (mem_req_strb),
      .lsu_idx   (lsu_idx),
      .dma_idx   (dma_idx),
      .vld       (ent_vld[i]),
      .idx       (ent_idx[i]),
      .data      (ent_data[i]),
      .strb      (ent_strb[i]),
      .lsu_hit   (lsu_hit[i]),
      .dma_hit   (dma_hit[i])
    );
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (lsu_wr) tail <= tail + 1'b1;
      if (drain)  head <= head + 1'b1;
      cnt <= cnt + CNT_W'(lsu_wr) - CNT_W'(drain);
    end
  end

  // Walk oldest to youngest so the youngest matching store owns each byte.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    fwd_slot = head;
    for (int k = 0; k < SB_DEPTH; k++) begin
      fwd_slot = head + PTR_W'(k);
      if (lsu_hit[fwd_slot]) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (ent_strb[fwd_slot][b]) begin
            fwd_data[b*8 +: 8] = ent_data[fwd_slot][b*8 +: 8];
            fwd_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    port_en    = lsu_rd || dma_gnt || drain;
    port_we    = 1'b0;
    port_idx   = lsu_idx;
    port_wdata = ent_data[head];
    port_be    = ent_strb[head];
    if (!lsu_rd) begin
      if (drain) begin
        port_we  = 1'b1;
        port_idx = ent_idx[head];
      end else if (dma_gnt) begin
        port_we    = (dma_req_opcode == TOY_BUS_WRITE);
        port_idx   = dma_idx;
        port_wdata = dma_req_data;
        port_be    = dma_req_strb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (port_en && port_we) begin
      for (int b = 0; b < STRB_W; b++)
        if (port_be[b]) mem[port_idx][b*8 +: 8] <= port_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rdata      <= '0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      lsu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      ack_hold   <= '0;
      dma_hold   <= '0;
    end else begin
      if (port_en && !port_we) rdata <= mem[port_idx];
      if (lsu_rd) begin
        fwd_data_q <= fwd_data;
        fwd_mask_q <= fwd_mask;
      end
      lsu_ack_q <= lsu_rd;
      dma_ack_q <= dma_gnt && (dma_req_opcode == TOY_BUS_READ);
      if (lsu_ack_q) ack_hold <= merged;
      if (dma_ack_q) dma_hold <= rdata;
    end
  end

  always_comb begin
    merged = rdata;
    for (int b = 0; b < STRB_W; b++)
      if (fwd_mask_q[b]) merged[b*8 +: 8] = fwd_data_q[b*8 +: 8];
  end

  // mem_ack_data is held after the response cycle; the AMO path reads it one cycle late
  assign mem_ack_vld  = lsu_ack_q;
  assign mem_ack_data = lsu_ack_q ? merged : ack_hold;
  assign dma_ack_vld  = dma_ack_q;
  assign dma_ack_data = dma_ack_q ? rdata : dma_hold;
endmodule

// File: tb/tb_toy_dmem_sbuf.sv
// Random + directed bench for toy_dmem_sbuf against a program-order memory model.
module tb_toy_dmem_sbuf;
  localparam int SB_DEPTH = 4;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic        clk, rst_n;
  logic        mem_req_vld, mem_req_rdy, mem_req_opcode, mem_ack_vld, mem_ack_rdy;
  logic [31:0] mem_req_addr, mem_req_data, mem_ack_data;
  logic [3:0]  mem_req_strb;
  logic        dma_req_vld, dma_req_rdy, dma_req_opcode, dma_ack_vld;
  logic [31:0] dma_req_addr, dma_req_data, dma_ack_data;
  logic [3:0]  dma_req_strb;
  logic [2:0]  sb_count;

  toy_dmem_sbuf dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_strb(mem_req_strb), .mem_req_opcode(mem_req_opcode),
    .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy), .mem_ack_data(mem_ack_data),
    .dma_req_vld(dma_req_vld), .dma_req_rdy(dma_req_rdy), .dma_req_addr(dma_req_addr),
    .dma_req_data(dma_req_data), .dma_req_strb(dma_req_strb), .dma_req_opcode(dma_req_opcode),
    .dma_ack_vld(dma_ack_vld), .dma_ack_data(dma_ack_data), .sb_count(sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // architectural memory in program order, indexed by word
  logic [31:0] view [4096];
  logic [31:0] last_md, last_dd, exp_md, exp_dd;
  logic        exp_mv, exp_dv, last_rdy;

  int          lsu_op;          // 0 idle, 1 read, 2 write
  logic [31:0] lsu_addr, lsu_data;
  logic [3:0]  lsu_strb;
  logic        dma_on, dma_wr;
  logic [31:0] dma_addr, dma_data;
  logic [3:0]  dma_strb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic step();
    logic g;
    logic [11:0] li, di;
    @(negedge clk);
    mem_req_vld    = (lsu_op != 0);
    mem_req_opcode = (lsu_op == 2) ? WR : RD;
    mem_req_addr   = lsu_addr;
    mem_req_data   = lsu_data;
    mem_req_strb   = lsu_strb;
    dma_req_vld    = dma_on;
    dma_req_opcode = dma_wr ? WR : RD;
    dma_req_addr   = dma_addr;
    dma_req_data   = dma_data;
    dma_req_strb   = dma_strb;
    #4;
    last_rdy = dma_req_rdy;
    g  = dma_on && dma_req_rdy;
    li = lsu_addr[13:2];
    di = dma_addr[13:2];
    exp_mv = 1'b0;
    exp_dv = 1'b0;
    // DMA is ordered before a same-cycle LSU write: the store only reaches SRAM later
    if (g) begin
      chk("dma_gnt_occ", {31'b0, sb_count < SB_DEPTH - 1}, 32'd1);
      if (dma_wr) view[di] = merge(view[di], dma_data, dma_strb);
      else begin exp_dv = 1'b1; exp_dd = view[di]; end
      dma_on = 1'b0;
    end
    if (lsu_op == 1) begin exp_mv = 1'b1; exp_md = view[li]; end
    else if (lsu_op == 2 && lsu_strb != 4'h0) view[li] = merge(view[li], lsu_data, lsu_strb);
    @(posedge clk);
    #1;
    chk("req_rdy", {31'b0, mem_req_rdy}, 32'd1);
    chk("sb_bound", {31'b0, sb_count <= SB_DEPTH}, 32'd1);
    chk("mem_ack_vld", {31'b0, mem_ack_vld}, {31'b0, exp_mv});
    if (exp_mv) begin chk("mem_ack_data", mem_ack_data, exp_md); last_md = exp_md; end
    else chk("mem_ack_hold", mem_ack_data, last_md);
    chk("dma_ack_vld", {31'b0, dma_ack_vld}, {31'b0, exp_dv});
    if (exp_dv) begin chk("dma_ack_data", dma_ack_data, exp_dd); last_dd = exp_dd; end
    else chk("dma_ack_hold", dma_ack_data, last_dd);
    lsu_op = 0;
  endtask

  task automatic lsu_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    lsu_op = 2; lsu_addr = a; lsu_data = d; lsu_strb = s; step();
  endtask
  task automatic lsu_r(input logic [31:0] a);
    lsu_op = 1; lsu_addr = a; lsu_data = '0; lsu_strb = '0; step();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic dma_arm(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dma_on = 1'b1; dma_wr = w; dma_addr = a; dma_data = d; dma_strb = s;
  endtask
  task automatic dma_wait(input string tag);
    for (int i = 0; i < 30 && dma_on; i++) step();
    chk(tag, {31'b0, dma_on}, 32'd0);
  endtask

  logic [31:0] pre_addr [13];
  logic [31:0] sav0, sav1;
  logic [2:0]  cnt_before;

  initial begin
    rst_n = 1'b1; mem_ack_rdy = 1'b1;
    mem_req_vld = 0; mem_req_opcode = 0; mem_req_addr = 0; mem_req_data = 0; mem_req_strb = 0;
    dma_req_vld = 0; dma_req_opcode = 0; dma_req_addr = 0; dma_req_data = 0; dma_req_strb = 0;
    lsu_op = 0; lsu_addr = 0; lsu_data = 0; lsu_strb = 0;
    dma_on = 0; dma_wr = 0; dma_addr = 0; dma_data = 0; dma_strb = 0;
    last_md = 0; last_dd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sb_count", {29'b0, sb_count}, 32'd0);
    chk("rst_mem_ack_vld", {31'b0, mem_ack_vld}, 32'd0);
    chk("rst_mem_ack_data", mem_ack_data, 32'd0);
    chk("rst_dma_ack_vld", {31'b0, dma_ack_vld}, 32'd0);
    chk("rst_dma_ack_data", dma_ack_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // preload every word the bench touches through the DMA port
    for (int i = 0; i < 8; i++) pre_addr[i] = 32'h100 + 32'(i * 4);
    pre_addr[8] = 32'h40; pre_addr[9] = 32'h44; pre_addr[10] = 32'h80;
    pre_addr[11] = 32'h200; pre_addr[12] = 32'h300;
    for (int i = 0; i < 13; i++) begin
      dma_arm(1'b1, pre_addr[i], (pre_addr[i] == 32'h80) ? 32'd5 : $urandom, 4'hF);
      dma_wait("preload_gnt");
    end

    // store then immediate load: forwarded, then again from SRAM
    lsu_w(32'h100, 32'hAABBCCDD, 4'hF);
    lsu_r(32'h100);
    chk("t1_fwd", mem_ack_data, 32'hAABBCCDD);
    idle(6);
    chk("t1_drained", {29'b0, sb_count}, 32'd0);
    lsu_r(32'h100);
    chk("t1_sram", mem_ack_data, 32'hAABBCCDD);

    // youngest byte wins
    lsu_w(32'h40, 32'h11223344, 4'hF);
    lsu_w(32'h40, 32'h0000EE00, 4'b0010);
    lsu_r(32'h40);
    chk("t2_merge", mem_ack_data, 32'h1122EE44);
    idle(4);

    // back-to-back stores with the DMA requesting throughout
    for (int i = 0; i < 4; i++) begin
      if (!dma_on) dma_arm(1'b0, 32'h104, 32'h0, 4'h0);
      lsu_w(32'h108 + 32'(i * 4), $urandom, 4'hF);
    end
    dma_wait("t3_dma_gnt");
    idle(6);
    chk("t3_drained", {29'b0, sb_count}, 32'd0);
    for (int i = 0; i < 4; i++) lsu_r(32'h108 + 32'(i * 4));

    // AMO: load returns old value, held through the following store
    lsu_r(32'h80);
    chk("t4_ld", mem_ack_data, 32'd5);
    lsu_w(32'h80, 32'd8, 4'hF);
    chk("t4_hold", mem_ack_data, 32'd5);
    idle(3);
    lsu_r(32'h80);
    chk("t4_new", mem_ack_data, 32'd8);

    // SC-fail store is dropped
    cnt_before = sb_count;
    lsu_w(32'h200, 32'hDEADBEEF, 4'h0);
    chk("t5_cnt", {29'b0, sb_count}, {29'b0, cnt_before});
    idle(3);
    lsu_r(32'h200);

    // DMA read hazards on a buffered store
    lsu_w(32'h300, 32'h0BADF00D, 4'hF);
    dma_arm(1'b0, 32'h300, 32'h0, 4'h0);
    step();
    chk("t6_blocked", {31'b0, last_rdy}, 32'd0);
    dma_wait("t6_dma_gnt");
    chk("t6_dma_data", dma_ack_data, 32'h0BADF00D);
    idle(3);

    // reset with two stores buffered discards them
    sav0 = view[12'h010]; sav1 = view[12'h011];
    dma_arm(1'b0, 32'h11C, 32'h0, 4'h0);
    lsu_w(32'h40, 32'h12345678, 4'hF);
    dma_arm(1'b0, 32'h11C, 32'h0, 4'h0);
    lsu_w(32'h44, 32'h9ABCDEF0, 4'hF);
    chk("t7_cnt2", {29'b0, sb_count}, 32'd2);
    rst_n = 1'b1;
    mem_req_vld = 1'b0; dma_req_vld = 1'b0;
    #1;
    chk("t7_rst_cnt", {29'b0, sb_count}, 32'd0);
    chk("t7_rst_mack", mem_ack_data, 32'd0);
    chk("t7_rst_dack", dma_ack_data, 32'd0);
    chk("t7_rst_dvld", {31'b0, dma_ack_vld}, 32'd0);
    view[12'h010] = sav0; view[12'h011] = sav1;
    last_md = 0; last_dd = 0; dma_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    lsu_r(32'h40);
    lsu_r(32'h44);

    // random traffic, upper address bits randomised to exercise wrap
    for (int n = 0; n < 400; n++) begin
      lsu_op   = $urandom_range(0, 2);
      lsu_addr = {$urandom_range(0, 32'h3FFFF), 12'h040 + 12'($urandom_range(0, 7)), 2'($urandom)};
      lsu_data = $urandom;
      lsu_strb = 4'($urandom);
      if (!dma_on && $urandom_range(0, 2) == 0)
        dma_arm(1'($urandom), {$urandom_range(0, 32'h3FFFF), 12'h040 + 12'($urandom_range(0, 7)), 2'b00},
                $urandom, 4'($urandom));
      step();
    end
    dma_wait("rand_dma_gnt");
    idle(6);
    for (int i = 0; i < 8; i++) lsu_r(32'h100 + 32'(i * 4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
